// File: rtl/seg_scan_disp_pkg.sv
// Shared constants for the scanned 4-digit BCD display.
// Holds the gfedcba segment patterns, the dp bit index and the digit-state type.
package seg_scan_disp_pkg;

    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;

    localparam int DP_BIT = 7;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } digit_t;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to gfedcba decoder, active-high segments.
// Ports: bcd (digit code), blank (force all segments off), seg (g..a pattern).
module seg7_dec
    import seg_scan_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = PAT_0;
                4'd1:    seg = PAT_1;
                4'd2:    seg = PAT_2;
                4'd3:    seg = PAT_3;
                4'd4:    seg = PAT_4;
                4'd5:    seg = PAT_5;
                4'd6:    seg = PAT_6;
                4'd7:    seg = PAT_7;
                4'd8:    seg = PAT_8;
                4'd9:    seg = PAT_9;
                default: seg = 7'h00;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_disp.sv
// 4-digit BCD up-counter with a multiplexed 7-segment display driver.
// Ports: clk, rst (sync, active-high), inc_en, clr, wei_clk (scan wave),
//        seg[7:0] (dp,g..a), wei[3:0] (digit select), count_bcd[15:0].
module seg_scan_disp
    import seg_scan_disp_pkg::*;
#(
    parameter int   BLANK_LZ = 1,
    parameter logic SEG_ON   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        clr,
    input  logic        wei_clk,
    output logic [7:0]  seg,
    output logic [3:0]  wei,
    output logic [15:0] count_bcd
);

    logic [15:0] count_q;
    logic [15:0] cnt_nxt;
    logic        carry;
    logic        prev_wk;
    logic        scan_ev;
    digit_t      state;
    digit_t      state_nxt;
    digit_t      disp;
    digit_t      disp_nxt;
    logic        live;
    logic        live_nxt;
    logic [3:0]  zero_up;
    logic [3:0]  sel_bcd;
    logic        blank;
    logic [6:0]  pat;
    logic [7:0]  seg_d;
    logic [3:0]  wei_d;

    assign count_bcd = count_q;
    assign scan_ev   = wei_clk & ~prev_wk;

    // Increment ripples through all four digits in one cycle.
    always_comb begin
        cnt_nxt = count_q;
        carry   = inc_en;
        if (clr) begin
            cnt_nxt = 16'h0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (count_q[4*i +: 4] >= 4'd9) begin
                        cnt_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_nxt[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (scan_ev) begin
            case (state)
                S0:      state_nxt = S1;
                S1:      state_nxt = S2;
                S2:      state_nxt = S3;
                default: state_nxt = S0;
            endcase
        end
    end

    // A scan event latches the current state as the shown digit, so the
    // first event after reset shows digit 0. Until then the display is dark.
    assign disp_nxt = scan_ev ? state : disp;
    assign live_nxt = live | scan_ev;

    // zero_up[k]: digit k and every more-significant digit are zero.
    assign zero_up[3] = (count_q[15:12] == 4'd0);
    assign zero_up[2] = zero_up[3] && (count_q[11:8] == 4'd0);
    assign zero_up[1] = zero_up[2] && (count_q[7:4] == 4'd0);
    assign zero_up[0] = zero_up[1] && (count_q[3:0] == 4'd0);

    assign sel_bcd = count_q[{disp_nxt, 2'b00} +: 4];
    assign blank   = (BLANK_LZ != 0) && (disp_nxt != S0)
                     && zero_up[disp_nxt];

    seg7_dec u_dec (
        .bcd   (sel_bcd),
        .blank (blank),
        .seg   (pat)
    );

    always_comb begin
        seg_d = SEG_ON ? {1'b0, pat} : ~{1'b0, pat};
        seg_d[DP_BIT] = ~SEG_ON;
        wei_d = SEG_ON ? (4'b0001 << disp_nxt) : ~(4'b0001 << disp_nxt);
        if (!live_nxt) begin
            seg_d = {8{~SEG_ON}};
            wei_d = {4{~SEG_ON}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 16'h0000;
            prev_wk <= 1'b0;
            disp    <= S0;
            live    <= 1'b0;
            wei     <= {4{~SEG_ON}};
            seg     <= {8{~SEG_ON}};
        end else begin
            count_q <= cnt_nxt;
            prev_wk <= wei_clk;
            disp    <= disp_nxt;
            live    <= live_nxt;
            wei     <= wei_d;
            seg     <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_disp.sv
// Self-checking bench for seg_scan_disp with an integer-count display model.
// Directed scenarios pin known values; a random phase follows.
module tb_seg_scan_disp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inc_en = 1'b0;
    logic        clr = 1'b0;
    logic        wei_clk = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  wei;
    logic [15:0] count_bcd;

    int checks = 0;
    int failures = 0;

    seg_scan_disp #(
        .BLANK_LZ (1),
        .SEG_ON   (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (inc_en),
        .clr       (clr),
        .wei_clk   (wei_clk),
        .seg       (seg),
        .wei       (wei),
        .count_bcd (count_bcd)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: count as an integer, shown digit index, next digit to show.
    int   m_cnt = 0;
    int   m_next = 0;
    int   m_show = 0;
    bit   m_live = 0;
    bit   m_prev = 0;
    bit   m_ok = 0;
    logic [7:0]  e_seg;
    logic [3:0]  e_wei;
    logic [15:0] e_cnt;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] exp_seg_of(int v, int d);
        int p;
        int dig;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        dig = (v / p) % 10;
        if (d > 0 && v < p) return 8'hFF;
        return {1'b1, ~pat[dig]};
    endfunction

    always @(posedge clk) begin
        int old;
        old = m_cnt;
        if (rst) begin
            m_cnt = 0;
            m_next = 0;
            m_live = 0;
            m_prev = 0;
            m_ok = 1;
        end else begin
            if (wei_clk && !m_prev) begin
                m_show = m_next;
                m_next = (m_next + 1) % 4;
                m_live = 1;
            end
            m_prev = wei_clk;
            if (clr) m_cnt = 0;
            else if (inc_en) m_cnt = (m_cnt + 1) % 10000;
        end
        e_cnt = to_bcd(m_cnt);
        if (rst || !m_live) begin
            e_wei = 4'hF;
            e_seg = 8'hFF;
        end else begin
            e_wei = ~(4'b0001 << m_show);
            e_seg = exp_seg_of(old, m_show);
        end
        #1;
        if (m_ok) begin
            chk("cyc_wei", {28'd0, wei}, {28'd0, e_wei});
            chk("cyc_seg", {24'd0, seg}, {24'd0, e_seg});
            chk("cyc_cnt", {16'd0, count_bcd}, {16'd0, e_cnt});
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_edge();
        wei_clk = 1'b1;
        step(1);
        wei_clk = 1'b0;
        step(1);
    endtask

    task automatic scan_to(int k);
        for (int i = 0; i < 4 && m_next != k; i++) scan_edge();
        scan_edge();
    endtask

    task automatic pulses(int n);
        for (int i = 0; i < n; i++) begin
            inc_en = 1'b1;
            step(1);
            inc_en = 1'b0;
            step(1);
        end
    endtask

    task automatic hold_inc(int n);
        inc_en = 1'b1;
        step(n);
        inc_en = 1'b0;
        step(1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(1);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_wei", {28'd0, wei}, 32'hF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_cnt", {16'd0, count_bcd}, 32'h0);

        scan_edge();
        chk("first_wei", {28'd0, wei}, 32'hE);
        chk("first_seg", {24'd0, seg}, 32'hC0);

        pulses(7);
        chk("seven_cnt", {16'd0, count_bcd}, 32'h0007);
        scan_to(1);
        chk("seven_s1", {24'd0, seg}, 32'hFF);
        scan_edge();
        chk("seven_s2", {24'd0, seg}, 32'hFF);
        scan_edge();
        chk("seven_s3", {24'd0, seg}, 32'hFF);
        scan_edge();
        chk("seven_s0", {24'd0, seg}, 32'hF8);

        scan_edge();
        chk("scan_w1", {28'd0, wei}, 32'hD);
        scan_edge();
        chk("scan_w2", {28'd0, wei}, 32'hB);
        scan_edge();
        chk("scan_w3", {28'd0, wei}, 32'h7);
        scan_edge();
        chk("scan_w0", {28'd0, wei}, 32'hE);

        do_clr();
        hold_inc(9999);
        chk("pre_9999", {16'd0, count_bcd}, 32'h9999);
        scan_to(2);
        chk("seg_9999", {24'd0, seg}, {24'd0, 8'h80 | ~{1'b0, 7'h6F}});
        inc_en = 1'b1;
        step(1);
        inc_en = 1'b0;
        chk("wrap_cnt", {16'd0, count_bcd}, 32'h0);
        step(1);
        scan_to(0);
        chk("wrap_s0", {24'd0, seg}, 32'hC0);
        scan_edge();
        chk("wrap_s1", {24'd0, seg}, 32'hFF);

        hold_inc(42);
        chk("pre_42", {16'd0, count_bcd}, 32'h0042);
        inc_en = 1'b1;
        clr = 1'b1;
        step(1);
        inc_en = 1'b0;
        clr = 1'b0;
        chk("clr_pri", {16'd0, count_bcd}, 32'h0);
        step(1);
        chk("clr_nolost", {16'd0, count_bcd}, 32'h0);

        hold_inc(1009);
        chk("pre_1009", {16'd0, count_bcd}, 32'h1009);
        scan_to(2);
        chk("lz_mid", {24'd0, seg}, 32'hC0);
        wei_clk = 1'b1;
        inc_en = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        inc_en = 1'b0;
        wei_clk = 1'b0;
        chk("mid_rst_wei", {28'd0, wei}, 32'hF);
        chk("mid_rst_seg", {24'd0, seg}, 32'hFF);
        chk("mid_rst_cnt", {16'd0, count_bcd}, 32'h0);
        step(1);
        scan_edge();
        chk("post_rst_wei", {28'd0, wei}, 32'hE);

        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom % 500) == 0;
            clr = ($urandom % 60) == 0;
            inc_en = ($urandom % 3) != 0;
            if (($urandom % 3) == 0) wei_clk = ~wei_clk;
            step(1);
        end
        rst = 1'b0;
        clr = 1'b0;
        inc_en = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
